// File: rtl/uart_led_cmd.sv
// uart_led_cmd: framed LED command decoder.
// Parses SYNC/CMD/ARG/CHK frames from the UART byte stream and drives NUM_CH
// LEDs, each either steady-on or blinking. It also reports good frames, bad
// frames and a saturating error count.
module uart_led_cmd #(
  parameter int NUM_CH      = 4,
  parameter int CLK_HZ      = 50000000,
  parameter int BLINK_HZ    = 2,
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [NUM_CH-1:0] led,
  output logic              frame_ok,
  output logic              frame_err,
  output logic [7:0]        err_cnt
);

  // Blink half-period in clk cycles, and the counter widths.
  localparam int HP = CLK_HZ / (2 * BLINK_HZ);
  localparam int BW = (HP > 1) ? $clog2(HP) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [7:0]    SYNC    = 8'hA5;
  localparam logic [BW-1:0] HP_LAST = BW'(HP - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  localparam logic [7:0] CMD_SEL   = 8'h01;
  localparam logic [7:0] CMD_MASK  = 8'h02;
  localparam logic [7:0] CMD_BLINK = 8'h03;
  localparam logic [7:0] CMD_CLEAR = 8'h04;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GOT_SYNC = 2'd1,
    GOT_CMD  = 2'd2,
    GOT_ARG  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [7:0]          r_cmd;
  logic [7:0]          r_arg;
  logic [TW-1:0]       r_to_cnt;
  logic [BW-1:0]       r_blink_cnt;
  logic                r_phase;
  logic [NUM_CH-1:0]   r_on;
  logic [NUM_CH-1:0]   r_blink;
  logic [NUM_CH-1:0]   r_led;
  logic                r_frame_ok;
  logic                r_frame_err;
  logic [7:0]          r_err_cnt;

  logic                w_chk_rx;
  logic                w_timeout;
  logic                w_chk_ok;
  logic                w_cmd_known;
  logic                w_apply;
  logic                w_reject;
  logic [NUM_CH-1:0]   w_sel;
  logic [NUM_CH-1:0]   w_mask;
  logic [NUM_CH-1:0]   w_led_next;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: advance on each byte; in a partial frame an expired
  // inter-byte timer abandons the frame unless a byte arrives that same cycle.
  always_comb begin
    w_state_next = r_state;
    w_chk_rx     = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE: begin
        if (rx_valid && (rx_data == SYNC)) begin
          w_state_next = GOT_SYNC;
        end
      end
      GOT_SYNC: begin
        if (rx_valid) begin
          w_state_next = GOT_CMD;
        end else if (r_to_cnt == TO_LAST) begin
          w_state_next = IDLE;
          w_timeout    = 1'b1;
        end
      end
      GOT_CMD: begin
        if (rx_valid) begin
          w_state_next = GOT_ARG;
        end else if (r_to_cnt == TO_LAST) begin
          w_state_next = IDLE;
          w_timeout    = 1'b1;
        end
      end
      GOT_ARG: begin
        if (rx_valid) begin
          w_state_next = IDLE;
          w_chk_rx     = 1'b1;
        end else if (r_to_cnt == TO_LAST) begin
          w_state_next = IDLE;
          w_timeout    = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Capture CMD and ARG bytes as they arrive; a SYNC value in the CMD slot is
  // deliberately taken as a command byte (no resynchronisation).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cmd <= 8'h00;
      r_arg <= 8'h00;
    end else if (rx_valid) begin
      if (r_state == GOT_SYNC) begin
        r_cmd <= rx_data;
      end
      if (r_state == GOT_CMD) begin
        r_arg <= rx_data;
      end
    end
  end

  // Inter-byte timer: idle at zero outside a frame, restarted by every byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if ((r_state == IDLE) || rx_valid || w_timeout) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // Frame evaluation happens while the CHK byte is on rx_data.
  assign w_chk_ok    = (rx_data == (SYNC ^ r_cmd ^ r_arg));
  assign w_cmd_known = (r_cmd == CMD_SEL) || (r_cmd == CMD_MASK) ||
                       (r_cmd == CMD_BLINK) || (r_cmd == CMD_CLEAR);
  assign w_apply     = w_chk_rx && w_chk_ok && w_cmd_known;
  assign w_reject    = (w_chk_rx && !(w_chk_ok && w_cmd_known)) || w_timeout;
  assign w_mask      = r_arg[NUM_CH-1:0];

  // One-hot select of the ARG channel; an ARG beyond the last channel
  // matches no bit, so the result is all zeros.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_sel
      assign w_sel[gi] = (r_arg == 8'(gi));
    end
  endgenerate

  // Mode registers change only on a fully validated frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_on    <= '0;
      r_blink <= '0;
    end else if (w_apply) begin
      case (r_cmd)
        CMD_SEL:   r_on    <= w_sel;
        CMD_MASK:  r_on    <= w_mask;
        CMD_BLINK: r_blink <= w_mask;
        CMD_CLEAR: begin
          r_on    <= '0;
          r_blink <= '0;
        end
        default: begin
          r_on    <= r_on;
          r_blink <= r_blink;
        end
      endcase
    end
  end

  // Status pulses and the saturating error counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_cnt   <= 8'h00;
    end else begin
      r_frame_ok  <= w_apply;
      r_frame_err <= w_reject;
      if (w_reject && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'h01;
      end
    end
  end

  // Free-running blink timebase; commands never disturb it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
    end else if (r_blink_cnt == HP_LAST) begin
      r_blink_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  // Per-channel LED value: steady when not blinking, gated by phase otherwise.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_led
      assign w_led_next[gi] = r_on[gi] & (r_blink[gi] ? r_phase : 1'b1);
    end
  endgenerate

  // Registered LED drive.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_led <= '0;
    end else begin
      r_led <= w_led_next;
    end
  end

  assign led       = r_led;
  assign frame_ok  = r_frame_ok;
  assign frame_err = r_frame_err;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_uart_led_cmd.sv
// Bench for uart_led_cmd: table of frames with hand-written expectations,
// hand sequences for blink, timeout, saturation, reset and back-to-back, and
// a randomized byte stream checked every cycle against a frame-level model.
module tb_uart_led_cmd;
  localparam int NUM_CH      = 4;
  localparam int CLK_HZ      = 1000;
  localparam int BLINK_HZ    = 100;
  localparam int TIMEOUT_CYC = 20;
  localparam int HP          = CLK_HZ / (2 * BLINK_HZ);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [3:0] led;
  logic       frame_ok;
  logic       frame_err;
  logic [7:0] err_cnt;

  uart_led_cmd #(
    .NUM_CH(NUM_CH), .CLK_HZ(CLK_HZ), .BLINK_HZ(BLINK_HZ), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .led(led), .frame_ok(frame_ok), .frame_err(frame_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  // Reference model: collects frame bytes in a queue, counts idle cycles
  // inside a frame, and derives the blink phase from elapsed cycles.
  logic [7:0] m_buf[$];
  int         m_idle = 0;
  int         m_k = 0;
  int         m_cnt = 0;
  logic [3:0] m_on = '0;
  logic [3:0] m_blink = '0;
  logic [3:0] m_led = '0;
  logic       m_ok = 1'b0;
  logic       m_err = 1'b0;

  always @(posedge clk) begin
    logic [3:0] led_n;
    logic [7:0] c;
    logic [7:0] a;
    bit         phase;
    if (!rst_n) begin
      m_buf.delete();
      m_idle = 0; m_k = 0; m_cnt = 0;
      m_on = '0; m_blink = '0; m_led = '0; m_ok = 1'b0; m_err = 1'b0;
    end else begin
      phase = ((m_k / HP) % 2) == 0;
      for (int i = 0; i < NUM_CH; i++) led_n[i] = m_on[i] && (!m_blink[i] || phase);
      m_ok = 1'b0;
      m_err = 1'b0;
      if (rx_valid) begin
        m_idle = 0;
        if (m_buf.size() != 0 || rx_data == 8'hA5) m_buf.push_back(rx_data);
        if (m_buf.size() == 4) begin
          c = m_buf[1];
          a = m_buf[2];
          if (m_buf[3] == (8'hA5 ^ c ^ a) && c >= 8'd1 && c <= 8'd4) begin
            case (c)
              8'd1: m_on = (a < NUM_CH) ? (4'b0001 << a) : 4'b0000;
              8'd2: m_on = a[3:0];
              8'd3: m_blink = a[3:0];
              default: begin m_on = '0; m_blink = '0; end
            endcase
            m_ok = 1'b1;
          end else begin
            m_err = 1'b1;
            if (m_cnt < 255) m_cnt++;
          end
          m_buf.delete();
        end
      end else if (m_buf.size() != 0) begin
        m_idle++;
        if (m_idle == TIMEOUT_CYC) begin
          m_buf.delete();
          m_idle = 0;
          m_err = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end
      end
      m_k++;
      m_led = led_n;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (led !== m_led || frame_ok !== m_ok || frame_err !== m_err || err_cnt !== m_cnt[7:0]) begin
        failures++;
        $display("FAIL model t=%0t led got=%b want=%b ok got=%b want=%b err got=%b want=%b cnt got=%0d want=%0d",
                 $time, led, m_led, frame_ok, m_ok, frame_err, m_err, err_cnt, m_cnt);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Drive one byte; called at a falling edge, returns at the next one.
  task automatic put(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k);
    put(8'hA5); put(c); put(a); put(k);
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] arg;
    logic [7:0] chk_b;
    logic       ok;
    logic       err;
    logic [3:0] led_e;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[12];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation did not finish got=running want=done");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int pulses;
    int pulse_at;
    int last;
    int ntog;
    logic prev;
    logic [7:0] c;
    logic [7:0] a;
    logic [7:0] k;
    int gap;

    vecs[0]  = '{8'h01, 8'h02, 8'hA6, 1'b1, 1'b0, 4'b0100, 8'd0};
    vecs[1]  = '{8'h01, 8'h07, 8'hA3, 1'b1, 1'b0, 4'b0000, 8'd0};
    vecs[2]  = '{8'h02, 8'h0B, 8'hAC, 1'b1, 1'b0, 4'b1011, 8'd0};
    vecs[3]  = '{8'h01, 8'h02, 8'h00, 1'b0, 1'b1, 4'b1011, 8'd1};
    vecs[4]  = '{8'h09, 8'h00, 8'hAC, 1'b0, 1'b1, 4'b1011, 8'd2};
    vecs[5]  = '{8'h01, 8'h03, 8'hA7, 1'b1, 1'b0, 4'b1000, 8'd2};
    vecs[6]  = '{8'h02, 8'h0F, 8'hA8, 1'b1, 1'b0, 4'b1111, 8'd2};
    vecs[7]  = '{8'h04, 8'h00, 8'hA1, 1'b1, 1'b0, 4'b0000, 8'd2};
    vecs[8]  = '{8'h04, 8'h55, 8'hF4, 1'b1, 1'b0, 4'b0000, 8'd2};
    vecs[9]  = '{8'h02, 8'hFA, 8'h5D, 1'b1, 1'b0, 4'b1010, 8'd2};
    vecs[10] = '{8'h00, 8'h00, 8'hA5, 1'b0, 1'b1, 4'b1010, 8'd3};
    vecs[11] = '{8'h02, 8'h0F, 8'hAF, 1'b0, 1'b1, 4'b1010, 8'd4};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_led", led, 4'b0000);
    chk("rst_ok", frame_ok, 1'b0);
    chk("rst_err", frame_err, 1'b0);
    chk("rst_cnt", err_cnt, 8'd0);
    mon_en = 1'b1;
    rst_n = 1'b1;
    idle(2);

    // Table-driven frames.
    for (int i = 0; i < 12; i++) begin
      send_frame(vecs[i].cmd, vecs[i].arg, vecs[i].chk_b);
      chk("vec_ok", frame_ok, vecs[i].ok);
      chk("vec_err", frame_err, vecs[i].err);
      chk("vec_cnt", err_cnt, vecs[i].cnt);
      @(negedge clk);
      chk("vec_led", led, vecs[i].led_e);
      $display("vec %0d: A5 %h %h %h ok=%b err=%b led=%b cnt=%0d",
               i, vecs[i].cmd, vecs[i].arg, vecs[i].chk_b, frame_ok, frame_err, led, err_cnt);
      idle(2);
    end

    // Mask then blink on channel 0.
    send_frame(8'h02, 8'h0B, 8'hAC);
    idle(1);
    send_frame(8'h03, 8'h01, 8'hA7);
    @(negedge clk);
    prev = led[0];
    last = -1;
    ntog = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("blink_steady", led[3:1], 3'b101);
      if (led[0] !== prev) begin
        if (last >= 0) chk("blink_period", i - last, HP);
        last = i;
        ntog++;
        prev = led[0];
      end
    end
    chk("blink_toggles", ntog >= 5, 1'b1);
    $display("blink: toggles=%0d", ntog);

    // Timeout: garbage is silent, a stalled frame times out exactly once.
    send_frame(8'h04, 8'h00, 8'hA1);
    put(8'h3C); put(8'h11);
    idle(3);
    chk("garbage_cnt", err_cnt, 8'd4);
    put(8'hA5); put(8'h01);
    pulses = 0;
    pulse_at = -1;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (frame_err === 1'b1) begin
        pulses++;
        pulse_at = i;
      end
    end
    chk("to_pulses", pulses, 1);
    chk("to_cycle", pulse_at, TIMEOUT_CYC);
    chk("to_cnt", err_cnt, 8'd5);
    $display("timeout: pulses=%0d at=%0d cnt=%0d", pulses, pulse_at, err_cnt);
    send_frame(8'h04, 8'h00, 8'hA1);
    chk("to_clear_ok", frame_ok, 1'b1);
    @(negedge clk);
    chk("to_clear_led", led, 4'b0000);

    // A byte arriving in the last allowed cycle keeps the frame alive.
    put(8'hA5); idle(TIMEOUT_CYC - 1);
    put(8'h02); idle(TIMEOUT_CYC - 1);
    put(8'h05); idle(TIMEOUT_CYC - 1);
    put(8'hA2);
    chk("edge_ok", frame_ok, 1'b1);
    @(negedge clk);
    chk("edge_led", led, 4'b0101);
    chk("edge_cnt", err_cnt, 8'd5);
    $display("edge: led=%b cnt=%0d", led, err_cnt);

    // Saturation.
    for (int i = 0; i < 260; i++) send_frame(8'h01, 8'h02, 8'h00);
    chk("sat_err", frame_err, 1'b1);
    idle(1);
    chk("sat_cnt", err_cnt, 8'd255);
    $display("saturate: cnt=%0d led=%b", err_cnt, led);

    // Reset mid-frame, then the rest of the old frame must not complete it.
    put(8'hA5); put(8'h02);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_led", led, 4'b0000);
    chk("mrst_cnt", err_cnt, 8'd0);
    chk("mrst_ok", frame_ok, 1'b0);
    chk("mrst_err", frame_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    put(8'h0F); put(8'hA8);
    idle(2);
    chk("mrst_discard", err_cnt, 8'd0);
    send_frame(8'h02, 8'h0F, 8'hA8);
    chk("mrst_frame_ok", frame_ok, 1'b1);
    @(negedge clk);
    chk("mrst_led_after", led, 4'b1111);
    $display("reset: led=%b cnt=%0d", led, err_cnt);

    // Back-to-back frames with no gaps.
    put(8'hA5); put(8'h02); put(8'h05); put(8'hA2);
    chk("b2b_ok1", frame_ok, 1'b1);
    put(8'hA5);
    chk("b2b_led1", led, 4'b0101);
    put(8'h02); put(8'h0A); put(8'hAD);
    chk("b2b_ok2", frame_ok, 1'b1);
    @(negedge clk);
    chk("b2b_led2", led, 4'b1010);
    $display("b2b: led=%b", led);

    // Randomized stream, checked by the model every cycle.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        put(8'($urandom_range(0, 255)));
        $display("rand %0d: stray byte", i);
      end else begin
        c = 8'($urandom_range(0, 5));
        a = 8'($urandom_range(0, 255));
        k = 8'hA5 ^ c ^ a;
        if ($urandom_range(0, 3) == 0) k = k ^ 8'(1 << $urandom_range(0, 7));
        for (int b = 0; b < 4; b++) begin
          case (b)
            0: put(8'hA5);
            1: put(c);
            2: put(a);
            default: put(k);
          endcase
          gap = ($urandom_range(0, 24) == 0) ? $urandom_range(15, 24) : $urandom_range(0, 2);
          idle(gap);
        end
        $display("rand %0d: A5 %h %h %h led=%b cnt=%0d", i, c, a, k, led, err_cnt);
      end
    end
    idle(TIMEOUT_CYC + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
